aes_block_decryptor: RTL and testbench
======================================

# aes_block_decryptor

Iterative AES inverse cipher (FIPS-197 InvCipher) that accepts one 128-bit ciphertext block over a valid/ready handshake and returns the plaintext one round per clock. It is the receive-side counterpart of the encrypt path: it consumes ciphertext produced by the encryptor together with the expanded key schedule from `KeyExpansion`. It sits between a ciphertext source and a plaintext consumer, with independent back-pressure on each side.

## Interface
- `Nk`, 4: key length in 32-bit words; legal values 4, 6, 8.
- `Nr`, 10: number of rounds; must equal `Nk + 6`. Any other combination is a compile-time error.
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high.
- `round_keys`  in  128*(Nr+1): expanded schedule; round 0 key at `[128*(Nr+1)-1 -: 128]`, round Nr key at `[127:0]`.
- `in_valid`  in  1: `in_block` is valid.
- `in_ready`  out  1: block can be accepted this cycle.
- `in_block`  in  128: ciphertext; byte 0 in `[127:120]`.
- `out_valid`  out  1: `out_block` holds plaintext.
- `out_ready`  in  1: consumer accepts `out_block`.
- `out_block`  out  128: plaintext, same byte order.
- `busy`  out  1: rounds in progress.
- `round_idx`  out  4: round key index for the next edge; 0 when not busy.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`: state <= `in_block ^ rk[Nr]`, `round_idx` <= Nr-1, go ROUND.
- ROUND, `round_idx` ≥ 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[round_idx]); decrement.
- ROUND, `round_idx` = 0: `out_block` <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; `out_valid` <= 1; go DONE.
- DONE: hold `out_block` and `out_valid` until `out_ready`. `in_ready` = `out_ready` in DONE (back-to-back): if `out_valid & out_ready & in_valid`, the new block is loaded the same edge and FSM goes ROUND; if only `out_ready`, go IDLE.
- `in_ready`=0 in ROUND; `in_valid` ignored there.
- GF(2^8) arithmetic uses polynomial 0x11B; InvMixColumns coefficients 0e, 0b, 0d, 09.
- Out-of-range `round_idx` is unreachable; no wrap-around.

## Timing
- Reset values: `in_ready`=0 while `reset`=1, then 1 (IDLE); `out_valid`=0, `out_block`=0, `busy`=0, `round_idx`=0.
- Latency: accept on edge E0; `out_valid` rises after edge E(Nr): Nr+1 cycles from the accept cycle (11/13/15 for Nk=4/6/8).
- Throughput with `out_ready` tied high: one block per Nr+1 cycles.
- `out_block` stable whenever `out_valid`=1 and not yet accepted.
- `reset` mid-operation: in-flight block discarded, no output produced, all outputs return to reset values next cycle.
- `round_keys` sampled every ROUND cycle; must be stable from accept until `out_valid` unless the latch option is built in.

## Configuration
- `AES_DEC_KEYLATCH_EN` defined: a 128*(Nr+1)-bit register captures `round_keys` at the accept edge; rounds use the latched copy, so `round_keys` may change at any time after acceptance.
- Not defined: no key register; rounds read `round_keys` live; changing it mid-block corrupts that block (legal, unchecked).

## Structure
- Shared package `aes_pkg`: inverse S-box function, `xtime`/`gmul` functions, InvShiftRows byte-index constants, FSM state enum, `Nr` derivation from `Nk`.
- One combinational sub-module `aes_inv_round` (inputs: state, round key, `final` flag; output: next state); FSM, registers, handshake stay in the top.

## Test plan
- Nk=4, key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, `out_ready`=1 -> `out_block`=00112233445566778899aabbccddeeff, `out_valid` high exactly 11 cycles after accept.
- Nk=6, key 000102…17, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext at 13 cycles; Nk=8, key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> same plaintext at 15 cycles.
- `out_ready`=0 for 20 cycles after `out_valid` -> `out_block` held, `in_ready`=0, `in_valid` pulses ignored; then `out_ready`=1 -> IDLE next cycle.
- Back-to-back: two Nk=4 blocks, `in_valid`, `out_ready` held 1 -> second accepted on the edge first is consumed; second result 11 cycles later.
- Assert `reset` at round 5 -> `out_valid` never rises for that block, `busy`=0 and `in_ready`=1 the cycle after `reset` drops.
- With `AES_DEC_KEYLATCH_EN`: change `round_keys` to all-zeros one cycle after accept -> plaintext still 00112233…eeff; without it, output differs.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decrypt helpers: inverse S-box, GF(2^8) arithmetic,
// InvShiftRows byte map, FSM state type and round-count derivation.
package aes_pkg;

  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned ROUND_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } dec_state_e;

  // Output byte i of InvShiftRows takes input byte INV_SHIFT_IDX[i] (byte 0 = MSB).
  localparam int INV_SHIFT_IDX [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic int unsigned nr_from_nk(input int unsigned nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] rk_i,
  input  logic               final_i,
  output logic [BLOCK_W-1:0] state_o
);

  logic [BLOCK_W-1:0] sub_c;
  logic [BLOCK_W-1:0] mix_c;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Row rotation and byte substitution commute, so do them in one pass.
  always_comb begin
    sub_c = '0;
    for (int i = 0; i < 16; i++) begin
      sub_c[8*(15-i) +: 8] = inv_sbox(state_i[8*(15-INV_SHIFT_IDX[i]) +: 8]);
    end
    sub_c = sub_c ^ rk_i;
  end

  always_comb begin
    mix_c = '0;
    for (int c = 0; c < 4; c++) begin
      mix_c[32*(3-c) +: 32] = inv_mix_col(sub_c[32*(3-c) +: 32]);
    end
  end

  assign state_o = final_i ? sub_c : mix_c;

endmodule

// File: rtl/aes_block_decryptor.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// Build option AES_DEC_KEYLATCH_EN: capture round_keys at accept and run from the copy.
module aes_block_decryptor
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [128*(Nr+1)-1:0]   round_keys,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_W-1:0]      in_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_W-1:0]      out_block,
  output logic                    busy,
  output logic [ROUND_IDX_W-1:0]  round_idx
);

  localparam int unsigned KEY_W = 128 * (Nr + 1);

  if (!((Nk == 4) || (Nk == 6) || (Nk == 8)) || (Nr != nr_from_nk(Nk))) begin : g_bad_cfg
    $error("aes_block_decryptor: illegal Nk/Nr combination");
  end

  dec_state_e             state_q, state_d;
  logic [BLOCK_W-1:0]     blk_q, blk_d;
  logic [BLOCK_W-1:0]     out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic [ROUND_IDX_W-1:0] round_q, round_d;
  logic                   busy_q, busy_d;
  logic                   accept_c;
  logic [KEY_W-1:0]       keys_c;
  logic [BLOCK_W-1:0]     rk_c [Nr+1];
  logic [BLOCK_W-1:0]     round_out_c;

  assign in_ready = ~reset & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept_c = in_valid & in_ready;

`ifdef AES_DEC_KEYLATCH_EN
  logic [KEY_W-1:0] keys_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      keys_q <= '0;
    end else if (accept_c) begin
      keys_q <= round_keys;
    end
  end

  assign keys_c = keys_q;
`else
  assign keys_c = round_keys;
`endif

  // Round key r lives at the slice counted down from the top of the schedule.
  for (genvar r = 0; r <= int'(Nr); r++) begin : g_rk
    assign rk_c[r] = keys_c[128*(Nr-r) +: 128];
  end

  aes_inv_round u_round (
    .state_i (blk_q),
    .rk_i    (rk_c[round_q]),
    .final_i (round_q == '0),
    .state_o (round_out_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      round_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      round_q     <= round_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; the initial AddRoundKey uses the live key (identical to a latched copy at accept).
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    round_d     = round_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          blk_d   = in_block ^ round_keys[BLOCK_W-1:0];
          round_d = ROUND_IDX_W'(Nr - 1);
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        blk_d = round_out_c;
        if (round_q == '0) begin
          out_d       = round_out_c;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          round_d = round_q - ROUND_IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            blk_d   = in_block ^ round_keys[BLOCK_W-1:0];
            round_d = ROUND_IDX_W'(Nr - 1);
            state_d = ST_ROUND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ROUND);
  end

  assign out_valid = out_valid_q;
  assign out_block = out_q;
  assign busy      = busy_q;
  assign round_idx = round_q;

endmodule

// File: tb/tb_aes_block_decryptor.sv
// Directed bench for aes_block_decryptor: FIPS-197 vectors for all key sizes,
// back-pressure, back-to-back, mid-block reset and the key-latch option.
module tb_aes_block_decryptor;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic         busy_a      [3];
  logic [127:0] in_block_a  [3];
  logic [127:0] out_block_a [3];
  logic [3:0]   ridx_a      [3];
  logic [1407:0] rk4;
  logic [1663:0] rk6;
  logic [1919:0] rk8;
  logic [1919:0] sched;
  logic [1407:0] rk4_saved;

  logic [7:0]   sbox_t [256];
  logic [127:0] sb_q [$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  aes_block_decryptor #(.Nk(4), .Nr(10)) dut0 (
    .clk(clk), .reset(reset), .round_keys(rk4),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_block(in_block_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_block(out_block_a[0]),
    .busy(busy_a[0]), .round_idx(ridx_a[0]));

  aes_block_decryptor #(.Nk(6), .Nr(12)) dut1 (
    .clk(clk), .reset(reset), .round_keys(rk6),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_block(in_block_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_block(out_block_a[1]),
    .busy(busy_a[1]), .round_idx(ridx_a[1]));

  aes_block_decryptor #(.Nk(8), .Nr(14)) dut2 (
    .clk(clk), .reset(reset), .round_keys(rk8),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_block(in_block_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_block(out_block_a[2]),
    .busy(busy_a[2]), .round_idx(ridx_a[2]));

  function automatic logic [7:0] tb_xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc = 8'h00;
    logic [7:0] p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = tb_xt(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Forward S-box from first principles: GF inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key 00 01 02 ... expanded into the low 128*(Nr+1) bits, round 0 on top.
  task automatic expand(input int nk, output logic [1919:0] s);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
    for (int j = nk; j < nw; j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end else if (nk > 6 && j % nk == 4) begin
        t = subw(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    s = '0;
    for (int j = 0; j < nw; j++) s[32*(nw-1-j) +: 32] = w[j];
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a block and hold it until the accept edge has passed.
  task automatic send(input int k, input logic [127:0] ct);
    int n = 0;
    in_block_a[k] = ct;
    in_valid_a[k] = 1'b1;
    while (in_ready_a[k] !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    cyc();
    in_valid_a[k] = 1'b0;
  endtask

  // Wait (bounded) for out_valid; check edges since accept and pop scoreboard.
  task automatic expect_out(input int k, input int lat, input string tag);
    int n = 0;
    logic [127:0] exp;
    while (out_valid_a[k] !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
    exp = 'x;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    check({tag, " data"}, out_block_a[k], exp);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k]  = 1'b0;
      out_ready_a[k] = 1'b1;
      in_block_a[k]  = '0;
    end
    build_sbox();
    expand(4, sched); rk4 = sched[1407:0];
    expand(6, sched); rk6 = sched[1663:0];
    expand(8, sched); rk8 = sched[1919:0];
    check("rk128 last round key", 128'(rk4[127:0]), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset values
    cyc();
    cyc();
    check("in_ready during reset", 128'(in_ready_a[0]), 128'(1'b0));
    check("out_valid reset", 128'(out_valid_a[0]), 128'(1'b0));
    check("out_block reset", out_block_a[0], 128'h0);
    check("busy reset", 128'(busy_a[0]), 128'(1'b0));
    check("round_idx reset", 128'(ridx_a[0]), 128'(4'd0));
    reset = 1'b0;
    #1;
    check("in_ready after reset", 128'(in_ready_a[0]), 128'(1'b1));

    // Known-answer vectors for each key size
    send(0, CT128);
    sb_q.push_back(PT);
    check("busy after accept", 128'(busy_a[0]), 128'(1'b1));
    check("round_idx after accept", 128'(ridx_a[0]), 128'(4'd9));
    check("in_ready in round", 128'(in_ready_a[0]), 128'(1'b0));
    expect_out(0, 10, "aes128");
    send(1, CT192);
    sb_q.push_back(PT);
    expect_out(1, 12, "aes192");
    send(2, CT256);
    sb_q.push_back(PT);
    expect_out(2, 14, "aes256");
    cyc();

    // Back-pressure: result held, input ignored
    out_ready_a[0] = 1'b0;
    send(0, CT128);
    sb_q.push_back(PT);
    expect_out(0, 10, "bp");
    for (int i = 0; i < 20; i++) begin
      in_valid_a[0] = 1'(i % 2);
      in_block_a[0] = {$urandom, $urandom, $urandom, $urandom};
      check("bp in_ready", 128'(in_ready_a[0]), 128'(1'b0));
      cyc();
      check("bp out_valid held", 128'(out_valid_a[0]), 128'(1'b1));
      check("bp out_block held", out_block_a[0], PT);
    end
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    cyc();
    check("bp released out_valid", 128'(out_valid_a[0]), 128'(1'b0));
    check("bp released busy", 128'(busy_a[0]), 128'(1'b0));
    check("bp released in_ready", 128'(in_ready_a[0]), 128'(1'b1));

    // Back-to-back: second block accepted on the edge that consumes the first
    in_block_a[0] = CT128;
    in_valid_a[0] = 1'b1;
    cyc();
    sb_q.push_back(PT);
    sb_q.push_back(PT);
    expect_out(0, 10, "b2b first");
    check("b2b in_ready in done", 128'(in_ready_a[0]), 128'(1'b1));
    cyc();
    in_valid_a[0] = 1'b0;
    check("b2b first consumed", 128'(out_valid_a[0]), 128'(1'b0));
    check("b2b second busy", 128'(busy_a[0]), 128'(1'b1));
    check("b2b second round_idx", 128'(ridx_a[0]), 128'(4'd9));
    expect_out(0, 10, "b2b second");
    cyc();

    // Reset in the middle of a block
    send(0, CT128);
    for (int i = 0; i < 5; i++) cyc();
    check("mid round_idx", 128'(ridx_a[0]), 128'(4'd4));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("post-reset busy", 128'(busy_a[0]), 128'(1'b0));
    check("post-reset in_ready", 128'(in_ready_a[0]), 128'(1'b1));
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (out_valid_a[0] !== 1'b0) seen++;
      end
      check("no output after reset", 128'(seen), 128'(0));
    end

    // Round keys cleared one cycle after accept
    rk4_saved = rk4;
    send(0, CT128);
    rk4 = '0;
`ifdef AES_DEC_KEYLATCH_EN
    sb_q.push_back(PT);
    expect_out(0, 10, "keylatch");
`else
    begin
      int n = 0;
      while (out_valid_a[0] !== 1'b1 && n < 100) begin
        cyc();
        n++;
      end
      check("live key latency", 128'(n), 128'(10));
      checks++;
      assert (out_block_a[0] !== PT) else begin
        errors++;
        $error("FAIL live key corrupts block: observed %h expected anything but %h", out_block_a[0], PT);
      end
    end
`endif
    rk4 = rk4_saved;
    cyc();
    check("scoreboard drained", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
